// File: rtl/spi_slave_axis.sv
// SPI slave: oversamples sclk/mosi/cs in clk_in, streams rx bytes out on
// AXI-Stream (tlast on final byte of a cs frame), returns tx bytes on miso.
module spi_slave_axis #(
    parameter bit         CLOCK_POLARITY_G = 1'b0,
    parameter bit         CLOCK_PHASE_G    = 1'b0,
    parameter bit         MSB_FIRST_G      = 1'b1,
    parameter logic [7:0] DEFAULT_TX_G     = 8'hFF
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       sclk,
    input  logic       mosi,
    input  logic       cs,
    output logic       miso,
    output logic       miso_oe,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    output logic       m_axis_tlast,
    output logic       busy,
    output logic       rx_overrun,
    output logic       tx_underrun,
    output logic       frame_error
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 3;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          sclk_pipe_q, sclk_pipe_d;
    logic [2:0]          cs_pipe_q, cs_pipe_d;
    logic [1:0]          mosi_pipe_q, mosi_pipe_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-1:0]   rx_sr_q, rx_sr_d;
    logic                pend_valid_q, pend_valid_d;
    logic [BYTE_W-1:0]   pend_data_q, pend_data_d;
    logic [BYTE_W-1:0]   tx_q, tx_d;
    logic [CNT_W-1:0]    tx_idx_q, tx_idx_d;
    logic                load_pend_q, load_pend_d;
    logic                out_valid_q, out_valid_d;
    logic [BYTE_W-1:0]   out_data_q, out_data_d;
    logic                out_last_q, out_last_d;
    logic                s_ready_q, s_ready_d;
    logic                underrun_q, underrun_d;
    logic                overrun_q, overrun_d;
    logic                ferr_q, ferr_d;
    logic                miso_q, miso_d;
    logic                busy_q, busy_d;

    logic                sclk_lead_c, sclk_trail_c, sample_c, shift_c;
    logic                cs_fall_c, cs_rise_c, mosi_s_c;
    logic                do_load, push, push_last;
    logic [BYTE_W-1:0]   rx_next;
    logic [CNT_W-1:0]    miso_sel;

    // Two-flop synchronizers plus one previous-value flop for edge detection
    always_comb begin
        sclk_pipe_d = {sclk_pipe_q[1:0], sclk};
        cs_pipe_d   = {cs_pipe_q[1:0], cs};
        mosi_pipe_d = {mosi_pipe_q[0], mosi};
    end

    assign sclk_lead_c  = (sclk_pipe_q[2] == CLOCK_POLARITY_G) && (sclk_pipe_q[1] != CLOCK_POLARITY_G);
    assign sclk_trail_c = (sclk_pipe_q[2] != CLOCK_POLARITY_G) && (sclk_pipe_q[1] == CLOCK_POLARITY_G);
    assign sample_c     = CLOCK_PHASE_G ? sclk_trail_c : sclk_lead_c;
    assign shift_c      = CLOCK_PHASE_G ? sclk_lead_c : sclk_trail_c;
    assign cs_fall_c    = cs_pipe_q[2] & ~cs_pipe_q[1];
    assign cs_rise_c    = ~cs_pipe_q[2] & cs_pipe_q[1];
    assign mosi_s_c     = mosi_pipe_q[1];

    // Frame FSM, rx shift/pending/output stages and tx load/shift
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        rx_sr_d      = rx_sr_q;
        pend_valid_d = pend_valid_q;
        pend_data_d  = pend_data_q;
        tx_d         = tx_q;
        tx_idx_d     = tx_idx_q;
        load_pend_d  = 1'b0;
        out_valid_d  = out_valid_q && !m_axis_tready;
        out_data_d   = out_data_q;
        out_last_d   = out_last_q;
        s_ready_d    = 1'b0;
        underrun_d   = 1'b0;
        overrun_d    = 1'b0;
        ferr_d       = 1'b0;
        do_load      = 1'b0;
        push         = 1'b0;
        push_last    = 1'b0;
        rx_next      = MSB_FIRST_G ? {rx_sr_q[BYTE_W-2:0], mosi_s_c}
                                   : {mosi_s_c, rx_sr_q[BYTE_W-1:1]};

        case (state_q)
            ST_IDLE: begin
                if (cs_fall_c) begin
                    state_d   = ST_ACTIVE;
                    bit_cnt_d = '0;
                    tx_idx_d  = '0;
                    do_load   = !CLOCK_PHASE_G;
                end
            end
            ST_ACTIVE: begin
                if (cs_rise_c) begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = '0;
                    ferr_d    = (bit_cnt_q != '0);
                    if (pend_valid_q) begin
                        push         = 1'b1;
                        push_last    = 1'b1;
                        pend_valid_d = 1'b0;
                    end
                end else begin
                    do_load = load_pend_q;
                    if (sample_c) begin
                        rx_sr_d   = rx_next;
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == CNT_W'(7)) begin
                            push         = pend_valid_q;
                            pend_data_d  = rx_next;
                            pend_valid_d = 1'b1;
                            load_pend_d  = !CLOCK_PHASE_G;
                        end
                    end
                    if (shift_c) begin
                        if (bit_cnt_q == '0) begin
                            // byte boundary: CPHA=1 loads here, CPHA=0 already loaded
                            do_load  = CLOCK_PHASE_G;
                            tx_idx_d = '0;
                        end else begin
                            tx_idx_d = tx_idx_q + CNT_W'(1);
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (do_load) begin
            tx_idx_d = '0;
            if (s_axis_tvalid) begin
                tx_d      = s_axis_tdata;
                s_ready_d = 1'b1;
            end else begin
                tx_d       = DEFAULT_TX_G;
                underrun_d = 1'b1;
            end
        end

        // A push into a stalled full output register drops the new byte
        if (push) begin
            if (out_valid_q && !m_axis_tready) begin
                overrun_d = 1'b1;
            end else begin
                out_valid_d = 1'b1;
                out_data_d  = pend_data_q;
                out_last_d  = push_last;
            end
        end

        miso_sel = MSB_FIRST_G ? CNT_W'(CNT_W'(7) - tx_idx_d) : tx_idx_d;
        busy_d   = (state_d == ST_ACTIVE);
        miso_d   = busy_d ? tx_d[miso_sel] : 1'b0;
    end

    // State and datapath registers
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q      <= ST_IDLE;
            sclk_pipe_q  <= {3{CLOCK_POLARITY_G}};
            cs_pipe_q    <= '0;
            mosi_pipe_q  <= '0;
            bit_cnt_q    <= '0;
            rx_sr_q      <= '0;
            pend_valid_q <= 1'b0;
            pend_data_q  <= '0;
            tx_q         <= '0;
            tx_idx_q     <= '0;
            load_pend_q  <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            s_ready_q    <= 1'b0;
            underrun_q   <= 1'b0;
            overrun_q    <= 1'b0;
            ferr_q       <= 1'b0;
            miso_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sclk_pipe_q  <= sclk_pipe_d;
            cs_pipe_q    <= cs_pipe_d;
            mosi_pipe_q  <= mosi_pipe_d;
            bit_cnt_q    <= bit_cnt_d;
            rx_sr_q      <= rx_sr_d;
            pend_valid_q <= pend_valid_d;
            pend_data_q  <= pend_data_d;
            tx_q         <= tx_d;
            tx_idx_q     <= tx_idx_d;
            load_pend_q  <= load_pend_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            s_ready_q    <= s_ready_d;
            underrun_q   <= underrun_d;
            overrun_q    <= overrun_d;
            ferr_q       <= ferr_d;
            miso_q       <= miso_d;
            busy_q       <= busy_d;
        end
    end

    assign miso          = miso_q;
    assign miso_oe       = busy_q;
    assign busy          = busy_q;
    assign s_axis_tready = s_ready_q;
    assign m_axis_tdata  = out_data_q;
    assign m_axis_tvalid = out_valid_q;
    assign m_axis_tlast  = out_last_q;
    assign rx_overrun    = overrun_q;
    assign tx_underrun   = underrun_q;
    assign frame_error   = ferr_q;

endmodule

// File: tb/tb_spi_slave_axis.sv
// Bench for spi_slave_axis: five instances (modes 0-3 MSB-first, mode 0 LSB-first)
// driven by a bit-banged SPI master, checked against a frame-level model.
module tb_spi_slave_axis;

    localparam int         NI     = 5;
    localparam logic [7:0] DEF_TX = 8'hFF;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic [NI-1:0] sclk_v, cs_v;
    logic          mosi;
    logic [7:0]    s_tdata;
    logic          s_tvalid;
    logic          m_tready;
    wire  [NI-1:0] miso_v, miso_oe_v, s_tready_v, m_tvalid_v, m_tlast_v;
    wire  [NI-1:0] busy_v, ovr_v, und_v, ferr_v;
    wire  [7:0]    m_tdata_a [NI];

    always #5 clk_in = ~clk_in;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        spi_slave_axis #(
            .CLOCK_POLARITY_G (g == 2 || g == 3),
            .CLOCK_PHASE_G    (g == 1 || g == 3),
            .MSB_FIRST_G      (g != 4),
            .DEFAULT_TX_G     (DEF_TX)
        ) u_dut (
            .clk_in        (clk_in),
            .rst_in        (rst_in),
            .sclk          (sclk_v[g]),
            .mosi          (mosi),
            .cs            (cs_v[g]),
            .miso          (miso_v[g]),
            .miso_oe       (miso_oe_v[g]),
            .s_axis_tdata  (s_tdata),
            .s_axis_tvalid (s_tvalid),
            .s_axis_tready (s_tready_v[g]),
            .m_axis_tdata  (m_tdata_a[g]),
            .m_axis_tvalid (m_tvalid_v[g]),
            .m_axis_tready (m_tready),
            .m_axis_tlast  (m_tlast_v[g]),
            .busy          (busy_v[g]),
            .rx_overrun    (ovr_v[g]),
            .tx_underrun   (und_v[g]),
            .frame_error   (ferr_v[g])
        );
    end

    typedef struct {
        int              inst;
        int              nb;
        logic [3:0][7:0] mo;
        int              lastbits;
        int              ntx;
        logic [3:0][7:0] tx;
        bit              hold;
        int              ebeats;
        logic [3:0][7:0] erx;
        logic [3:0]      elast;
        logic [3:0][7:0] emiso;
        int              erdy, eund, eovr, efe;
    } vec_t;

    typedef struct {
        int         inst;
        logic [7:0] data;
        logic       last;
    } beat_t;

    int         n_tests = 0;
    int         n_fail  = 0;
    beat_t      beats[$];
    logic [7:0] txq[$];
    int         cnt_rdy, cnt_und, cnt_ovr, cnt_fe;

    function automatic bit cpol_of(input int inst);
        return (inst == 2 || inst == 3);
    endfunction

    function automatic bit cpha_of(input int inst);
        return (inst == 1 || inst == 3);
    endfunction

    function automatic logic [3:0][7:0] b4(input logic [7:0] a, b, c, d);
        logic [3:0][7:0] r;
        r[0] = a; r[1] = b; r[2] = c; r[3] = d;
        return r;
    endfunction

    function automatic vec_t mk(input int inst, nb, input logic [3:0][7:0] mo,
                                input int lastbits, ntx, input logic [3:0][7:0] tx,
                                input bit hold, input int ebeats, input logic [3:0][7:0] erx,
                                input logic [3:0] elast, input logic [3:0][7:0] emiso,
                                input int erdy, eund, eovr, efe);
        vec_t v;
        v.inst = inst; v.nb = nb; v.mo = mo; v.lastbits = lastbits; v.ntx = ntx;
        v.tx = tx; v.hold = hold; v.ebeats = ebeats; v.erx = erx; v.elast = elast;
        v.emiso = emiso; v.erdy = erdy; v.eund = eund; v.eovr = eovr; v.efe = efe;
        return v;
    endfunction

    // Frame-level reference: counts load points, tx consumption and rx delivery
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        int   full, loads, cons;
        full  = (v.lastbits == 8) ? v.nb : v.nb - 1;
        loads = cpha_of(v.inst) ? v.nb : full + 1;
        cons  = (loads < v.ntx) ? loads : v.ntx;
        r.erdy = cons;
        r.eund = loads - cons;
        r.efe  = (v.lastbits != 8) ? 1 : 0;
        r.erx = '0; r.elast = '0; r.emiso = '0;
        for (int k = 0; k < full; k++) r.emiso[k] = (k < v.ntx) ? v.tx[k] : DEF_TX;
        if (v.hold) begin
            r.ebeats = (full > 0) ? 1 : 0;
            r.eovr   = (full > 0) ? full - 1 : 0;
            if (full > 0) begin
                r.erx[0]   = v.mo[0];
                r.elast[0] = (full == 1);
            end
        end else begin
            r.ebeats = full;
            r.eovr   = 0;
            for (int k = 0; k < full; k++) r.erx[k] = v.mo[k];
            if (full > 0) r.elast[full-1] = 1'b1;
        end
        return r;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // s_axis source: present queue head
    always @(posedge clk_in) begin
        #1;
        s_tvalid = (txq.size() > 0);
        s_tdata  = (txq.size() > 0) ? txq[0] : 8'h00;
    end

    // Monitor: m_axis beats, s_axis consumption and status pulses
    always @(negedge clk_in) begin
        beat_t bt;
        for (int i = 0; i < NI; i++) begin
            if (m_tvalid_v[i] && m_tready) begin
                bt.inst = i; bt.data = m_tdata_a[i]; bt.last = m_tlast_v[i];
                beats.push_back(bt);
            end
        end
        if ((|s_tready_v) && txq.size() > 0) void'(txq.pop_front());
        cnt_rdy += $countones(s_tready_v);
        cnt_und += $countones(und_v);
        cnt_ovr += $countones(ovr_v);
        cnt_fe  += $countones(ferr_v);
    end

    // Bit-banged SPI master: 16 clk_in per sclk period
    task automatic run_frame(input int inst, input int nb, input logic [3:0][7:0] mo,
                             input int last_bits, output logic [3:0][7:0] rd);
        bit         cpol, cpha, msb;
        int         idx;
        logic [7:0] cur;
        logic       rdbit;
        cpol = cpol_of(inst); cpha = cpha_of(inst); msb = (inst != 4);
        rd = '0;
        sclk_v[inst] = cpol;
        tick(2);
        cs_v[inst] = 1'b0;
        tick(6);
        for (int b = 0; b < nb; b++) begin
            cur = mo[b];
            for (int i = 0; i < ((b == nb - 1) ? last_bits : 8); i++) begin
                idx = msb ? 7 - i : i;
                if (!cpha) begin
                    mosi = cur[idx];
                    tick(8);
                    rdbit = miso_v[inst];
                    sclk_v[inst] = ~cpol;
                    tick(8);
                    sclk_v[inst] = cpol;
                end else begin
                    sclk_v[inst] = ~cpol;
                    mosi = cur[idx];
                    tick(8);
                    rdbit = miso_v[inst];
                    sclk_v[inst] = cpol;
                    tick(8);
                end
                rd[b][idx] = rdbit;
            end
        end
        tick(8);
        cs_v[inst] = 1'b1;
        tick(12);
    endtask

    task automatic apply(input vec_t v, input string tag);
        logic [3:0][7:0] rd;
        int              full;
        txq.delete();
        for (int k = 0; k < v.ntx; k++) txq.push_back(v.tx[k]);
        beats.delete();
        cnt_rdy = 0; cnt_und = 0; cnt_ovr = 0; cnt_fe = 0;
        m_tready = !v.hold;
        tick(3);
        run_frame(v.inst, v.nb, v.mo, v.lastbits, rd);
        if (v.hold) begin
            tick(20);
            m_tready = 1'b1;
        end
        tick(10);
        full = (v.lastbits == 8) ? v.nb : v.nb - 1;
        check($sformatf("%s_nbeats", tag), beats.size(), v.ebeats);
        for (int k = 0; k < v.ebeats && k < beats.size(); k++) begin
            check($sformatf("%s_rx%0d", tag, k), beats[k].data, v.erx[k]);
            check($sformatf("%s_last%0d", tag, k), beats[k].last, v.elast[k]);
            check($sformatf("%s_inst%0d", tag, k), beats[k].inst, v.inst);
        end
        for (int k = 0; k < full; k++)
            check($sformatf("%s_miso%0d", tag, k), rd[k], v.emiso[k]);
        check($sformatf("%s_tready", tag), cnt_rdy, v.erdy);
        check($sformatf("%s_underrun", tag), cnt_und, v.eund);
        check($sformatf("%s_overrun", tag), cnt_ovr, v.eovr);
        check($sformatf("%s_frame_err", tag), cnt_fe, v.efe);
    endtask

    function automatic int outs_of(input int i);
        return int'({miso_v[i], miso_oe_v[i], s_tready_v[i], m_tvalid_v[i], m_tlast_v[i],
                     busy_v[i], ovr_v[i], und_v[i], ferr_v[i], m_tdata_a[i]});
    endfunction

    initial begin
        vec_t tbl[9];
        vec_t rv;
        tbl[0] = mk(0, 1, b4(8'hA5, 0, 0, 0), 8, 1, b4(8'h3C, 0, 0, 0), 0,
                    1, b4(8'hA5, 0, 0, 0), 4'b0001, b4(8'h3C, 0, 0, 0), 1, 1, 0, 0);
        tbl[1] = mk(1, 3, b4(8'h01, 8'h80, 8'hFF, 0), 8, 3, b4(8'h11, 8'h22, 8'h33, 0), 0,
                    3, b4(8'h01, 8'h80, 8'hFF, 0), 4'b0100, b4(8'h11, 8'h22, 8'h33, 0), 3, 0, 0, 0);
        tbl[2] = mk(2, 3, b4(8'h01, 8'h80, 8'hFF, 0), 8, 3, b4(8'h11, 8'h22, 8'h33, 0), 0,
                    3, b4(8'h01, 8'h80, 8'hFF, 0), 4'b0100, b4(8'h11, 8'h22, 8'h33, 0), 3, 1, 0, 0);
        tbl[3] = mk(3, 3, b4(8'h01, 8'h80, 8'hFF, 0), 8, 3, b4(8'h11, 8'h22, 8'h33, 0), 0,
                    3, b4(8'h01, 8'h80, 8'hFF, 0), 4'b0100, b4(8'h11, 8'h22, 8'h33, 0), 3, 0, 0, 0);
        tbl[4] = mk(4, 1, b4(8'h01, 0, 0, 0), 8, 1, b4(8'h4D, 0, 0, 0), 0,
                    1, b4(8'h01, 0, 0, 0), 4'b0001, b4(8'h4D, 0, 0, 0), 1, 1, 0, 0);
        tbl[5] = mk(3, 2, b4(8'h5A, 8'hC3, 0, 0), 8, 0, '0, 0,
                    2, b4(8'h5A, 8'hC3, 0, 0), 4'b0010, b4(8'hFF, 8'hFF, 0, 0), 0, 2, 0, 0);
        tbl[6] = mk(0, 2, b4(8'h5A, 8'hC3, 0, 0), 8, 0, '0, 0,
                    2, b4(8'h5A, 8'hC3, 0, 0), 4'b0010, b4(8'hFF, 8'hFF, 0, 0), 0, 3, 0, 0);
        tbl[7] = mk(0, 3, b4(8'h10, 8'h20, 8'h30, 0), 8, 0, '0, 1,
                    1, b4(8'h10, 0, 0, 0), 4'b0000, b4(8'hFF, 8'hFF, 8'hFF, 0), 0, 4, 2, 0);
        tbl[8] = mk(0, 2, b4(8'h96, 8'hF0, 0, 0), 4, 1, b4(8'h77, 0, 0, 0), 0,
                    1, b4(8'h96, 0, 0, 0), 4'b0001, b4(8'h77, 0, 0, 0), 1, 1, 0, 1);

        rst_in = 1'b0; cs_v = '1; sclk_v = 5'b01100; mosi = 1'b0;
        m_tready = 1'b1; s_tvalid = 1'b0; s_tdata = 8'h00;
        tick(4);
        for (int i = 0; i < NI; i++) check($sformatf("reset_outs%0d", i), outs_of(i), 0);
        rst_in = 1'b1;
        tick(4);

        for (int t = 0; t < 9; t++) apply(tbl[t], $sformatf("vec%0d", t));

        // Reset asserted in the middle of a byte
        txq.delete();
        cs_v[0] = 1'b0; mosi = 1'b1;
        tick(6);
        for (int i = 0; i < 4; i++) begin
            tick(8); sclk_v[0] = 1'b1;
            tick(8); sclk_v[0] = 1'b0;
        end
        tick(2);
        check("midframe_busy", busy_v[0], 1);
        check("midframe_oe", miso_oe_v[0], 1);
        rst_in = 1'b0;
        @(negedge clk_in);
        check("rst_mid_outs", outs_of(0), 0);
        tick(2);
        rst_in = 1'b1;
        tick(6);
        check("rst_cs_low_busy", busy_v[0], 0);
        cs_v[0] = 1'b1;
        tick(10);
        check("rst_cs_high_busy", busy_v[0], 0);
        apply(tbl[0], "after_rst");

        // Randomized frames against the frame-level model
        for (int t = 0; t < 14; t++) begin
            rv.inst     = $urandom_range(0, NI - 1);
            rv.nb       = $urandom_range(1, 4);
            rv.lastbits = (rv.nb >= 2 && $urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 8;
            rv.ntx      = $urandom_range(0, 4);
            rv.hold     = ($urandom_range(0, 3) == 0);
            for (int k = 0; k < 4; k++) begin
                rv.mo[k] = 8'($urandom);
                rv.tx[k] = 8'($urandom);
            end
            apply(model(rv), $sformatf("rnd%0d", t));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
